// File: rtl/fifo_sync_level_if.sv
// rtl/fifo_sync_level_if.sv - handshake and status bundle for fifo_sync_level
// master drives write/read/clear requests; slave is the FIFO itself.
interface fifo_sync_level_if #(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 8
);
  logic                 w_inc_i;
  logic [DATA_SIZE-1:0] w_data_i;
  logic                 r_inc_i;
  logic [DATA_SIZE-1:0] r_data_o;
  logic                 clr_err_i;
  logic                 full_o;
  logic                 empty_o;
  logic                 almost_full_o;
  logic                 almost_empty_o;
  logic [ADDR_SIZE:0]   level_o;
  logic                 overflow_o;
  logic                 underflow_o;

  modport master (
    output w_inc_i, w_data_i, r_inc_i, clr_err_i,
    input  r_data_o, full_o, empty_o, almost_full_o, almost_empty_o,
           level_o, overflow_o, underflow_o
  );

  modport slave (
    input  w_inc_i, w_data_i, r_inc_i, clr_err_i,
    output r_data_o, full_o, empty_o, almost_full_o, almost_empty_o,
           level_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_sync_level.sv
// rtl/fifo_sync_level.sv - single-clock sample FIFO with level, thresholds and sticky errors
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module fifo_sync_level #(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 8,
  parameter int AF_THRESH = (1 << ADDR_SIZE) - 4,
  parameter int AE_THRESH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fifo_sync_level_if.slave  fif
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] FULL_LVL = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AF_LVL   = (ADDR_SIZE+1)'(AF_THRESH);
  localparam logic [ADDR_SIZE:0] AE_LVL   = (ADDR_SIZE+1)'(AE_THRESH);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic [ADDR_SIZE:0]   w_ptr;
  logic [ADDR_SIZE:0]   r_ptr;
  logic [ADDR_SIZE:0]   level_q;
  logic [ADDR_SIZE:0]   level_next;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [ADDR_SIZE-1:0] r_addr;
  logic                 full_q;
  logic                 empty_q;
  logic                 af_q;
  logic                 ae_q;
  logic                 ovf_q;
  logic                 unf_q;
  logic                 wr_acc;
  logic                 rd_acc;

  // Acceptance uses the registered flags only, so a read never frees room
  // for a write in the same cycle (and vice versa).
  assign wr_acc = fif.w_inc_i & ~full_q;
  assign rd_acc = fif.r_inc_i & ~empty_q;

  assign w_addr = w_ptr[ADDR_SIZE-1:0];
  assign r_addr = r_ptr[ADDR_SIZE-1:0];

  always_comb begin
    level_next = level_q;
    if (wr_acc && !rd_acc) begin
      level_next = level_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      level_next = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        w_ptr <= w_ptr + 1'b1;
      end
      if (rd_acc) begin
        r_ptr <= r_ptr + 1'b1;
      end
      level_q <= level_next;
      full_q  <= (level_next == FULL_LVL);
      empty_q <= (level_next == '0);
      af_q    <= (level_next >= AF_LVL);
      ae_q    <= (level_next <= AE_LVL);
      // A new error in the clearing cycle keeps the flag set.
      ovf_q   <= (fif.w_inc_i & full_q)  | (ovf_q & ~fif.clr_err_i);
      unf_q   <= (fif.r_inc_i & empty_q) | (unf_q & ~fif.clr_err_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && wr_acc) begin
      mem[w_addr] <= fif.w_data_i;
    end
  end

`ifdef FIFO_FWFT_EN
  assign fif.r_data_o = mem[r_addr];
`else
  logic [DATA_SIZE-1:0] r_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_data_q <= '0;
    end else if (rd_acc) begin
      r_data_q <= mem[r_addr];
    end
  end

  assign fif.r_data_o = r_data_q;
`endif

  assign fif.full_o         = full_q;
  assign fif.empty_o        = empty_q;
  assign fif.almost_full_o  = af_q;
  assign fif.almost_empty_o = ae_q;
  assign fif.level_o        = level_q;
  assign fif.overflow_o     = ovf_q;
  assign fif.underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_sync_level.sv
// tb/tb_fifo_sync_level.sv - self-checking bench for fifo_sync_level (depth 8, AF 6, AE 1)
module tb_fifo_sync_level;

  localparam int DW    = 12;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  always #5 clk_i = ~clk_i;

  fifo_sync_level_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) fif ();

  fifo_sync_level #(
    .DATA_SIZE(DW),
    .ADDR_SIZE(AW),
    .AF_THRESH(AF),
    .AE_THRESH(AE)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .fif  (fif)
  );

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    logic          clr;
    int            lvl;
    logic          full;
    logic          empty;
    logic          af;
    logic          ae;
    logic          ovf;
    logic          unf;
  } vec_t;

  vec_t tbl [20];

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_ovf   = 1'b0;
  logic          exp_unf   = 1'b0;

  function automatic vec_t mk(input logic w, input logic [DW-1:0] d, input logic r,
                              input logic clr, input int lvl, input logic full,
                              input logic empty, input logic af, input logic ae,
                              input logic ovf, input logic unf);
    vec_t v;
    v.w = w; v.d = d; v.r = r; v.clr = clr; v.lvl = lvl;
    v.full = full; v.empty = empty; v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: drive, advance the queue model, then compare everything.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic clr, input logic rst);
    int   n;
    logic wacc;
    logic racc;
    n = sb.size();
`ifdef FIFO_FWFT_EN
    if (n > 0) chk("fwft_head", 32'(fif.r_data_o), 32'(sb[0]));
`endif
    fif.w_inc_i   = w;
    fif.w_data_i  = d;
    fif.r_inc_i   = r;
    fif.clr_err_i = clr;
    rst_i         = rst;
    @(posedge clk_i);
    #1;
    if (!rst) begin
      sb.delete();
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
      exp_rdata = '0;
    end else begin
      wacc    = w && (n != DEPTH);
      racc    = r && (n != 0);
      exp_ovf = (w && (n == DEPTH)) || (exp_ovf && !clr);
      exp_unf = (r && (n == 0))     || (exp_unf && !clr);
      if (racc) exp_rdata = sb.pop_front();
      if (wacc) sb.push_back(d);
    end
    n = sb.size();
    chk("level",        32'(fif.level_o),        32'(n));
    chk("full",         32'(fif.full_o),         32'(n == DEPTH));
    chk("empty",        32'(fif.empty_o),        32'(n == 0));
    chk("almost_full",  32'(fif.almost_full_o),  32'(n >= AF));
    chk("almost_empty", 32'(fif.almost_empty_o), 32'(n <= AE));
    chk("overflow",     32'(fif.overflow_o),     32'(exp_ovf));
    chk("underflow",    32'(fif.underflow_o),    32'(exp_unf));
`ifndef FIFO_FWFT_EN
    chk("r_data",       32'(fif.r_data_o),       32'(exp_rdata));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Fill to full, overflow, drain, underflow, clear.
    for (int i = 0; i < 8; i++) begin
      tbl[i] = mk(1'b1, DW'(i + 1), 1'b0, 1'b0, i + 1, (i == 7), 1'b0,
                  (i + 1 >= 6), (i == 0), 1'b0, 1'b0);
    end
    tbl[8] = mk(1'b1, 12'hABC, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, '0, 1'b1, 1'b0, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, '0, 1'b1, 1'b0, 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, '0, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, '0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, '0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, '0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, '0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[17] = mk(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[18] = mk(1'b0, '0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[19] = mk(1'b0, '0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    fif.w_inc_i   = 1'b0;
    fif.w_data_i  = '0;
    fif.r_inc_i   = 1'b0;
    fif.clr_err_i = 1'b0;

    // Reset then idle.
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].clr, 1'b1);
      chk($sformatf("tbl%0d_level", i), 32'(fif.level_o),      32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_full", i),  32'(fif.full_o),       32'(tbl[i].full));
      chk($sformatf("tbl%0d_empty", i), 32'(fif.empty_o),      32'(tbl[i].empty));
      chk($sformatf("tbl%0d_af", i),    32'(fif.almost_full_o),  32'(tbl[i].af));
      chk($sformatf("tbl%0d_ae", i),    32'(fif.almost_empty_o), 32'(tbl[i].ae));
      chk($sformatf("tbl%0d_ovf", i),   32'(fif.overflow_o),   32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_unf", i),   32'(fif.underflow_o),  32'(tbl[i].unf));
    end

    // Simultaneous read/write at level 4, wrapping the pointers.
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, DW'(12'h100 + i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'(12'h200 + i), 1'b1, 1'b0, 1'b1);
      chk("simul_level4", 32'(fif.level_o), 32'd4);
    end

    // Simultaneous while full: write rejected, overflow set, level 7.
    for (int i = 0; i < 4; i++) step(1'b1, DW'(12'h300 + i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 12'h3AA, 1'b1, 1'b0, 1'b1);
    chk("full_simul_level", 32'(fif.level_o), 32'd7);
    chk("full_simul_ovf",   32'(fif.overflow_o), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, DW'(12'h3B0 + i), 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Drain past empty, then simultaneous while empty: read rejected, level 1.
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 12'h4BB, 1'b1, 1'b0, 1'b1);
    chk("empty_simul_level", 32'(fif.level_o), 32'd1);
    chk("empty_simul_unf",   32'(fif.underflow_o), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, DW'(12'h4C0 + i), 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Reset mid-stream with a write in the reset cycle.
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, DW'(12'h500 + i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 12'h5EE, 1'b0, 1'b0, 1'b0);
    chk("midrst_level", 32'(fif.level_o), 32'd0);
    chk("midrst_empty", 32'(fif.empty_o), 32'd1);
    step(1'b1, 12'h600, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
`ifndef FIFO_FWFT_EN
    chk("midrst_rdata", 32'(fif.r_data_o), 32'h600);
`endif
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

`ifdef FIFO_FWFT_EN
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h123, 1'b0, 1'b0, 1'b1);
    chk("fwft_first", 32'(fif.r_data_o), 32'h123);
    step(1'b1, 12'h456, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("fwft_pop", 32'(fif.r_data_o), 32'h456);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
